// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg -- shared definitions for the mem_bank block.
//
// Contents:
//   state_e      : controller state encoding (CLEAR sweep / RUN)
//   RD_LAT_MIN   : smallest supported read latency
//   RD_LAT_MAX   : largest supported read latency
//   mask_width() : number of byte lanes (write-mask bits) for a data width
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // One mask bit per byte lane.
    function automatic int mask_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/mem_bank_if.sv
// ---------------------------------------------------------------------------
// mem_bank_if -- request/response bundle of the mem_bank memory.
//
// Signal names carry the direction as seen from the memory (slave):
//   wr_en_i, wr_addr_i, wr_data_i, wr_mask_i : write request
//   rd_en_i, rd_addr_i                       : read request
//   ready_o                                  : requests accepted when high
//   rd_valid_o, rd_data_o                    : read response
//
// Modports:
//   master : requester side (drives requests, observes responses)
//   slave  : memory side
// ---------------------------------------------------------------------------
interface mem_bank_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    import mem_pkg::*;

    localparam int MASK_WIDTH = mask_width(DATA_WIDTH);

    logic                  wr_en_i;
    logic [ADDR_WIDTH-1:0] wr_addr_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic [MASK_WIDTH-1:0] wr_mask_i;
    logic                  rd_en_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic                  ready_o;
    logic                  rd_valid_o;
    logic [DATA_WIDTH-1:0] rd_data_o;

    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, wr_mask_i,
        output rd_en_i, rd_addr_i,
        input  ready_o, rd_valid_o, rd_data_o
    );

    modport slave (
        input  wr_en_i, wr_addr_i, wr_data_i, wr_mask_i,
        input  rd_en_i, rd_addr_i,
        output ready_o, rd_valid_o, rd_data_o
    );

endinterface

// File: rtl/mem_rd_pipe.sv
// ---------------------------------------------------------------------------
// mem_rd_pipe -- read response pipeline of mem_bank.
//
// The valid shift register is READ_LATENCY deep. Stage 0 data is the
// registered RAM output (already merged with any same-address write), which
// lives in the parent and arrives on head_data_i; stages 1..READ_LATENCY-1
// are held here. Each data stage only loads when a valid item moves into it,
// so the last stage (rd_data_o) keeps its value while rd_valid_o is low.
//
// Ports:
//   clk_i       : clock, state updates on the falling edge
//   reset_i     : synchronous active-high reset, clears valids and data
//   req_i       : read accepted on this edge
//   head_data_i : stage-0 data (registered RAM output with bypass applied)
//   rd_valid_o  : response valid
//   rd_data_o   : response data
// ---------------------------------------------------------------------------
module mem_rd_pipe
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_i,
    input  logic [DATA_WIDTH-1:0] head_data_i,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    generate
        if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_lat
            $error("mem_rd_pipe: READ_LATENCY out of range");
        end
    endgenerate

    logic [READ_LATENCY-1:0] vld_q;

    always_ff @(negedge clk_i) begin
        if (reset_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= req_i;
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    assign rd_valid_o = vld_q[READ_LATENCY-1];

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign rd_data_o = head_data_i;
        end else begin : g_latn
            logic [DATA_WIDTH-1:0] data_q [1:READ_LATENCY-1];

            always_ff @(negedge clk_i) begin
                if (reset_i) begin
                    for (int k = 1; k < READ_LATENCY; k++) begin
                        data_q[k] <= '0;
                    end
                end else begin
                    if (vld_q[0]) begin
                        data_q[1] <= head_data_i;
                    end
                    for (int k = 2; k < READ_LATENCY; k++) begin
                        if (vld_q[k-1]) begin
                            data_q[k] <= data_q[k-1];
                        end
                    end
                end
            end

            assign rd_data_o = data_q[READ_LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/mem_bank.sv
// ---------------------------------------------------------------------------
// mem_bank -- single-port-write / single-port-read byte-maskable memory with
// configurable read latency and write-first same-address behaviour.
//
// Build option:
//   MEM_BANK_CLEAR_EN : when defined, every reset release is followed by a
//                       sweep writing zero to every address (ascending, one
//                       per cycle); ready_o stays low until it finishes.
//                       When undefined, ready_o rises on the first cycle after
//                       reset and contents are undefined until written.
//
// Ports:
//   clk_i   : clock, all state changes on the falling edge
//   reset_i : synchronous active-high reset
//   bus     : mem_bank_if.slave (write request, read request, ready_o,
//             rd_valid_o, rd_data_o)
// ---------------------------------------------------------------------------
module mem_bank
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    mem_bank_if.slave  bus
);

    localparam int MASK_WIDTH = mask_width(DATA_WIDTH);
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    generate
        if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_dw
            $error("mem_bank: DATA_WIDTH must be a non-zero multiple of 8");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Controller
    // -----------------------------------------------------------------------
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  clr_we;

    always_ff @(negedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // CLEAR doubles as the post-reset holding state; without the sweep it
    // simply hands over to RUN on the first edge out of reset.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
`ifdef MEM_BANK_CLEAR_EN
                clr_we     = 1'b1;
                clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
                if (&clr_addr_q) begin
                    state_d = ST_RUN;
                end
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    logic ready;
    logic wr_acc;
    logic rd_acc;
    logic clr_we_eff;

    assign ready       = (state_q == ST_RUN);
    assign bus.ready_o = ready;

    // Gating with reset_i aborts anything presented on a reset edge.
    assign wr_acc     = ready & bus.wr_en_i & ~reset_i;
    assign rd_acc     = ready & bus.rd_en_i & ~reset_i;
    assign clr_we_eff = clr_we & ~reset_i;

    // -----------------------------------------------------------------------
    // Storage: one write process, one registered read process
    // -----------------------------------------------------------------------
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [MASK_WIDTH-1:0] mem_wmask;

    always_comb begin
        mem_we    = wr_acc | clr_we_eff;
        mem_waddr = bus.wr_addr_i;
        mem_wdata = bus.wr_data_i;
        mem_wmask = bus.wr_mask_i;
        if (clr_we_eff) begin
            mem_waddr = clr_addr_q;
            mem_wdata = '0;
            mem_wmask = '1;
        end
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(negedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (mem_wmask[b]) begin
                    mem_q[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd_word_q;

    always_ff @(negedge clk_i) begin
        if (reset_i) begin
            rd_word_q <= '0;
        end else if (rd_acc) begin
            rd_word_q <= mem_q[bus.rd_addr_i];
        end
    end

    // -----------------------------------------------------------------------
    // Write-first bypass. The RAM returns old contents on a same-address
    // collision, so the colliding write's bytes are captured alongside the
    // read and substituted lane by lane after the RAM output register.
    // -----------------------------------------------------------------------
    logic [MASK_WIDTH-1:0] byp_mask_q;
    logic [DATA_WIDTH-1:0] byp_data_q;

    always_ff @(negedge clk_i) begin
        if (reset_i) begin
            byp_mask_q <= '0;
            byp_data_q <= '0;
        end else if (rd_acc) begin
            byp_mask_q <= (wr_acc && (bus.wr_addr_i == bus.rd_addr_i)) ?
                          bus.wr_mask_i : '0;
            byp_data_q <= bus.wr_data_i;
        end
    end

    logic [DATA_WIDTH-1:0] head_data;

    generate
        for (genvar gi = 0; gi < MASK_WIDTH; gi++) begin : g_merge
            assign head_data[gi*8 +: 8] = byp_mask_q[gi] ? byp_data_q[gi*8 +: 8]
                                                         : rd_word_q[gi*8 +: 8];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Response pipeline
    // -----------------------------------------------------------------------
    mem_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req_i        (rd_acc),
        .head_data_i  (head_data),
        .rd_valid_o   (bus.rd_valid_o),
        .rd_data_o    (bus.rd_data_o)
    );

endmodule

// File: tb/tb_mem_bank.sv
// ---------------------------------------------------------------------------
// tb_mem_bank -- directed bench for mem_bank.
//
// Three instances share one clock: dut_a (READ_LATENCY=1) for masking,
// collision, hold and reset behaviour; dut_b (READ_LATENCY=3) for
// back-to-back reads; dut_c (READ_LATENCY=4) for reset with reads in flight.
// The DUT updates on the falling edge; the bench samples outputs and then
// drives new inputs on the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_bank;

`ifdef MEM_BANK_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif
    // Sample index (rising edges after reset release) at which ready_o is high.
    localparam int RISE_IDX = CLEAR_EN ? 256 : 1;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_bank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) ifa ();
    mem_bank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) ifb ();
    mem_bank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) ifc ();

    mem_bank #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(1)) dut_a (
        .clk_i   (clk),
        .reset_i (rst_a),
        .bus     (ifa)
    );

    mem_bank #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(3)) dut_b (
        .clk_i   (clk),
        .reset_i (rst_b),
        .bus     (ifb)
    );

    mem_bank #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(4)) dut_c (
        .clk_i   (clk),
        .reset_i (rst_c),
        .bus     (ifc)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic idle_all();
        ifa.wr_en_i = 1'b0; ifa.wr_addr_i = '0; ifa.wr_data_i = '0; ifa.wr_mask_i = '0;
        ifa.rd_en_i = 1'b0; ifa.rd_addr_i = '0;
        ifb.wr_en_i = 1'b0; ifb.wr_addr_i = '0; ifb.wr_data_i = '0; ifb.wr_mask_i = '0;
        ifb.rd_en_i = 1'b0; ifb.rd_addr_i = '0;
        ifc.wr_en_i = 1'b0; ifc.wr_addr_i = '0; ifc.wr_data_i = '0; ifc.wr_mask_i = '0;
        ifc.rd_en_i = 1'b0; ifc.rd_addr_i = '0;
    endtask

    // Called right after reset is released; returns how many rising edges
    // passed until ready_o was seen high (bounded at 400).
    task automatic ready_rise(input int which, output int idx);
        logic rdy;
        idx = 0;
        do begin
            @(posedge clk);
            idx++;
            case (which)
                0:       rdy = ifa.ready_o;
                1:       rdy = ifb.ready_o;
                default: rdy = ifc.ready_o;
            endcase
        end while (rdy !== 1'b1 && idx < 400);
    endtask

    task automatic a_write(input logic [7:0] addr, input logic [15:0] data,
                           input logic [1:0] mask);
        ifa.wr_en_i   = 1'b1;
        ifa.wr_addr_i = addr;
        ifa.wr_data_i = data;
        ifa.wr_mask_i = mask;
        @(posedge clk);
        ifa.wr_en_i = 1'b0;
    endtask

    // Issues one read on dut_a; lat is the number of rising edges until
    // rd_valid_o was seen (10 means it never came).
    task automatic a_read(input logic [7:0] addr, output logic [15:0] data,
                          output int lat);
        ifa.rd_en_i   = 1'b1;
        ifa.rd_addr_i = addr;
        @(posedge clk);
        ifa.rd_en_i = 1'b0;
        lat = 1;
        while (ifa.rd_valid_o !== 1'b1 && lat < 10) begin
            @(posedge clk);
            lat++;
        end
        data = ifa.rd_data_o;
    endtask

    task automatic test_reset();
        int          idx;
        int          lat;
        logic [15:0] d;
        repeat (3) @(posedge clk);
        total++;
        if (ifa.ready_o !== 1'b0) begin
            bad++; $display("FAIL reset_ready: got %b want 0", ifa.ready_o);
        end
        total++;
        if (ifa.rd_valid_o !== 1'b0) begin
            bad++; $display("FAIL reset_rd_valid: got %b want 0", ifa.rd_valid_o);
        end
        total++;
        if (ifa.rd_data_o !== 16'h0000) begin
            bad++; $display("FAIL reset_rd_data: got %h want 0000", ifa.rd_data_o);
        end
        rst_a = 1'b0;
        ready_rise(0, idx);
        total++;
        if (idx !== RISE_IDX) begin
            bad++; $display("FAIL ready_rise_a: got %0d want %0d", idx, RISE_IDX);
        end
        $display("reset: ready_o high after %0d cycles", idx);
`ifdef MEM_BANK_CLEAR_EN
        a_read(8'h00, d, lat);
        total++;
        if (lat !== 1 || d !== 16'h0000) begin
            bad++; $display("FAIL clear_rd_00: got %h lat %0d want 0000 lat 1", d, lat);
        end
        a_read(8'h7F, d, lat);
        total++;
        if (lat !== 1 || d !== 16'h0000) begin
            bad++; $display("FAIL clear_rd_7f: got %h lat %0d want 0000 lat 1", d, lat);
        end
        a_read(8'hFF, d, lat);
        total++;
        if (lat !== 1 || d !== 16'h0000) begin
            bad++; $display("FAIL clear_rd_ff: got %h lat %0d want 0000 lat 1", d, lat);
        end
        $display("clear: reads of 00/7f/ff done");
`endif
    endtask

    task automatic test_byte_mask();
        int          lat;
        logic [15:0] d;
        a_write(8'h10, 16'h1234, 2'b11);
        a_write(8'h10, 16'hABCD, 2'b10);
        a_read(8'h10, d, lat);
        total++;
        if (lat !== 1) begin
            bad++; $display("FAIL mask_latency: got %0d want 1", lat);
        end
        total++;
        if (d !== 16'hAB34) begin
            bad++; $display("FAIL mask_hi: got %h want ab34", d);
        end
        $display("mask: write 1234/11 then abcd/10 to 10 -> read %h", d);
        a_write(8'h10, 16'hFFFF, 2'b00);
        a_read(8'h10, d, lat);
        total++;
        if (d !== 16'hAB34) begin
            bad++; $display("FAIL mask_none: got %h want ab34", d);
        end
        $display("mask: write ffff/00 to 10 -> read %h", d);
        a_write(8'h11, 16'h5678, 2'b11);
        a_write(8'h11, 16'h00EF, 2'b01);
        a_read(8'h11, d, lat);
        total++;
        if (d !== 16'h56EF) begin
            bad++; $display("FAIL mask_lo: got %h want 56ef", d);
        end
        $display("mask: write 5678/11 then 00ef/01 to 11 -> read %h", d);
        a_write(8'hFF, 16'hBEEF, 2'b11);
        a_read(8'hFF, d, lat);
        total++;
        if (d !== 16'hBEEF) begin
            bad++; $display("FAIL top_addr: got %h want beef", d);
        end
        $display("mask: write beef to ff -> read %h", d);
    endtask

    task automatic test_collision();
        int          lat;
        logic [15:0] d;
        a_write(8'h20, 16'hAAAA, 2'b11);
        ifa.wr_en_i   = 1'b1;
        ifa.wr_addr_i = 8'h20;
        ifa.wr_data_i = 16'h5555;
        ifa.wr_mask_i = 2'b01;
        a_read(8'h20, d, lat);
        ifa.wr_en_i = 1'b0;
        total++;
        if (lat !== 1 || d !== 16'hAA55) begin
            bad++; $display("FAIL collide_same: got %h lat %0d want aa55 lat 1", d, lat);
        end
        $display("collision: wr 5555/01 + rd at 20 -> %h", d);
        @(posedge clk);
        total++;
        if (ifa.rd_valid_o !== 1'b0) begin
            bad++; $display("FAIL hold_valid: got %b want 0", ifa.rd_valid_o);
        end
        total++;
        if (ifa.rd_data_o !== 16'hAA55) begin
            bad++; $display("FAIL hold_data: got %h want aa55", ifa.rd_data_o);
        end
        $display("hold: rd_valid_o=%b rd_data_o=%h", ifa.rd_valid_o, ifa.rd_data_o);
        a_read(8'h20, d, lat);
        total++;
        if (d !== 16'hAA55) begin
            bad++; $display("FAIL collide_stored: got %h want aa55", d);
        end
        a_write(8'h21, 16'h1357, 2'b11);
        ifa.wr_en_i   = 1'b1;
        ifa.wr_addr_i = 8'h22;
        ifa.wr_data_i = 16'hFFFF;
        ifa.wr_mask_i = 2'b11;
        a_read(8'h21, d, lat);
        ifa.wr_en_i = 1'b0;
        total++;
        if (d !== 16'h1357) begin
            bad++; $display("FAIL collide_other: got %h want 1357", d);
        end
        $display("collision: wr 22 + rd 21 -> %h", d);
    endtask

    task automatic test_back_to_back();
        int          idx;
        logic        exp_v;
        logic [15:0] exp_d;
        rst_b = 1'b0;
        ready_rise(1, idx);
        total++;
        if (idx !== RISE_IDX) begin
            bad++; $display("FAIL ready_rise_b: got %0d want %0d", idx, RISE_IDX);
        end
        for (int i = 1; i <= 3; i++) begin
            ifb.wr_en_i   = 1'b1;
            ifb.wr_addr_i = 8'(i);
            ifb.wr_data_i = 16'h0101 * 16'(i);
            ifb.wr_mask_i = 2'b11;
            @(posedge clk);
        end
        ifb.wr_en_i = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            if (i >= 1) begin
                exp_v = (i >= 3 && i <= 5);
                total++;
                if (ifb.rd_valid_o !== exp_v) begin
                    bad++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, ifb.rd_valid_o, exp_v);
                end
                if (exp_v) begin
                    exp_d = 16'h0101 * 16'(i - 2);
                    total++;
                    if (ifb.rd_data_o !== exp_d) begin
                        bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, ifb.rd_data_o, exp_d);
                    end
                end
                $display("b2b: cycle %0d rd_valid_o=%b rd_data_o=%h", i, ifb.rd_valid_o, ifb.rd_data_o);
            end
            if (i < 3) begin
                ifb.rd_en_i   = 1'b1;
                ifb.rd_addr_i = 8'(i + 1);
            end else begin
                ifb.rd_en_i = 1'b0;
            end
            if (i < 6) @(posedge clk);
        end
    endtask

    task automatic test_reset_inflight();
        int idx;
        int vcount;
        rst_c = 1'b0;
        ready_rise(2, idx);
        total++;
        if (idx !== RISE_IDX) begin
            bad++; $display("FAIL ready_rise_c: got %0d want %0d", idx, RISE_IDX);
        end
        ifc.rd_en_i   = 1'b1;
        ifc.rd_addr_i = 8'h01;
        @(posedge clk);
        ifc.rd_addr_i = 8'h02;
        @(posedge clk);
        ifc.rd_en_i = 1'b0;
        rst_c       = 1'b1;
        @(posedge clk);
        total++;
        if (ifc.rd_valid_o !== 1'b0 || ifc.ready_o !== 1'b0 || ifc.rd_data_o !== 16'h0000) begin
            bad++;
            $display("FAIL inflight_reset_state: got valid %b ready %b data %h want 0 0 0000",
                     ifc.rd_valid_o, ifc.ready_o, ifc.rd_data_o);
        end
        rst_c  = 1'b0;
        vcount = 0;
        idx    = 0;
        do begin
            @(posedge clk);
            idx++;
            if (ifc.rd_valid_o === 1'b1) vcount++;
        end while (ifc.ready_o !== 1'b1 && idx < 400);
        repeat (6) begin
            @(posedge clk);
            if (ifc.rd_valid_o === 1'b1) vcount++;
        end
        total++;
        if (vcount !== 0) begin
            bad++; $display("FAIL inflight_dropped: got %0d valid cycles want 0", vcount);
        end
        total++;
        if (idx !== RISE_IDX) begin
            bad++; $display("FAIL inflight_ready_rise: got %0d want %0d", idx, RISE_IDX);
        end
        $display("inflight: valid cycles after reset=%0d, ready after %0d cycles", vcount, idx);
    endtask

    task automatic test_reset_ignore();
        int          idx;
        int          lat;
        logic [15:0] d;
        logic [15:0] exp_d;
        a_write(8'h40, 16'h1111, 2'b11);
        ifa.wr_en_i   = 1'b1;
        ifa.wr_addr_i = 8'h40;
        ifa.wr_data_i = 16'hDEAD;
        ifa.wr_mask_i = 2'b11;
        ifa.rd_en_i   = 1'b1;
        ifa.rd_addr_i = 8'h40;
        rst_a         = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            total++;
            if (ifa.rd_valid_o !== 1'b0) begin
                bad++; $display("FAIL ignore_valid[%0d]: got %b want 0", k, ifa.rd_valid_o);
            end
        end
        total++;
        if (ifa.ready_o !== 1'b0) begin
            bad++; $display("FAIL ignore_ready: got %b want 0", ifa.ready_o);
        end
        rst_a       = 1'b0;
        ifa.wr_en_i = 1'b0;
        ifa.rd_en_i = 1'b0;
        ready_rise(0, idx);
        total++;
        if (idx !== RISE_IDX) begin
            bad++; $display("FAIL ignore_ready_rise: got %0d want %0d", idx, RISE_IDX);
        end
        exp_d = CLEAR_EN ? 16'h0000 : 16'h1111;
        a_read(8'h40, d, lat);
        total++;
        if (d !== exp_d) begin
            bad++; $display("FAIL ignore_no_write: got %h want %h", d, exp_d);
        end
        $display("ignore: requests during reset, read 40 -> %h, ready after %0d", d, idx);
    endtask

    initial begin
        idle_all();
        test_reset();
        test_byte_mask();
        test_collision();
        test_back_to_back();
        test_reset_inflight();
        test_reset_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bank.md
MEM_BANK -- requirements
Module: mem_bank

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, meaning depth = 2^ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 16, meaning word width; SHALL be a multiple of 8.
REQ-003 Parameter READ_LATENCY, default 1, meaning cycles from read request to rd_valid_o; legal range 1..4.
REQ-004 clk_i  input  1  single clock; all state updates on its falling edge.
REQ-005 reset_i  input  1  reset, synchronous, active-high.
REQ-006 wr_en_i  input  1  write request.
REQ-007 wr_addr_i  input  ADDR_WIDTH  write address.
REQ-008 wr_data_i  input  DATA_WIDTH  write data.
REQ-009 wr_mask_i  input  DATA_WIDTH/8  per-byte write enable (1 = byte written).
REQ-010 rd_en_i  input  1  read request.
REQ-011 rd_addr_i  input  ADDR_WIDTH  read address.
REQ-012 ready_o  output  1  high when requests are accepted.
REQ-013 rd_valid_o  output  1  rd_data_o valid this cycle.
REQ-014 rd_data_o  output  DATA_WIDTH  read data, registered.

Function
REQ-015 FSM states CLEAR and RUN; ready_o = 1 only in RUN.
REQ-016 Requests while ready_o = 0 SHALL be ignored: no write, no rd_valid_o.
REQ-017 Write: in RUN with wr_en_i = 1, each byte b with wr_mask_i[b] = 1 SHALL be updated at that edge; bytes with mask 0 unchanged; wr_en_i with mask 0 SHALL write nothing.
REQ-018 Read: a request accepted at edge N SHALL produce rd_valid_o = 1 and rd_data_o for exactly one cycle starting after edge N+READ_LATENCY-1; back-to-back reads SHALL be accepted every cycle, one result per request, in order.
REQ-019 Same-address collision (rd and wr on same edge, same address) SHALL return write-first data: masked bytes from wr_data_i, unmasked bytes from old contents.
REQ-020 rd_data_o SHALL hold its last value when rd_valid_o = 0.
REQ-021 Address wrap: addresses are modulo 2^ADDR_WIDTH; no out-of-range case exists.

Reset
REQ-022 On reset_i = 1: rd_valid_o = 0, read pipeline valid bits cleared, rd_data_o = 0, ready_o = 0.
REQ-023 Reset mid-operation SHALL drop all in-flight reads (no rd_valid_o afterwards) and SHALL abort any write presented on that edge.
REQ-024 Memory contents are not reset except via REQ-026.

Configuration
REQ-025 Macro MEM_BANK_CLEAR_EN selects post-reset clearing.
REQ-026 With MEM_BANK_CLEAR_EN: after reset deasserts, FSM enters CLEAR and writes 0 to addresses 0..2^ADDR_WIDTH-1 in ascending order, one per cycle; ready_o rises on the cycle after address 2^ADDR_WIDTH-1 is written; reset during CLEAR restarts from address 0.
REQ-027 Without MEM_BANK_CLEAR_EN: no CLEAR sweep; FSM enters RUN and ready_o = 1 on the first cycle after reset deasserts; contents undefined, or loaded from file under the existing USE_ROM flow.

Structure
REQ-028 Shared package mem_pkg SHALL hold FSM state encoding, READ_LATENCY min/max constants, and byte-mask width derivation.
REQ-029 Read pipeline SHALL be a sub-module mem_rd_pipe (valid/data shift register, depth READ_LATENCY); storage array remains inferable BRAM (separate read and write processes).

Verification
REQ-030 CLEAR_EN, ADDR_WIDTH=8: deassert reset -> ready_o low 256 cycles then high; read 0x00, 0x7F and 0xFF -> all return 0x0000.
REQ-031 Write 0x1234 mask 2'b11 to 0x10, then write 0xABCD mask 2'b10 to 0x10, read 0x10 -> 0xAB34.
REQ-032 READ_LATENCY=3: reads to 0x01, 0x02, 0x03 on consecutive cycles -> rd_valid_o high three consecutive cycles, starting after the third edge, data in order.
REQ-033 Simultaneous write 0x5555 mask 2'b01 and read at 0x20 holding 0xAAAA -> rd_data_o = 0xAA55.
REQ-034 Reset asserted with two reads in flight (READ_LATENCY=4) -> rd_valid_o never rises for them; with CLEAR_EN, ready_o low again for 256 cycles.
REQ-035 Without CLEAR_EN: wr_en_i/rd_en_i driven during reset -> no write, no rd_valid_o; ready_o = 1 on the first cycle after reset deasserts.
